cw_reg_pipe: RTL and testbench
==============================

# cw_reg_pipe

Parametrised, flow-controlled register pipeline for the digital clock datapath. It generalises the plain per-clock data register to DEPTH stages of WIDTH bits, each stage with its own valid bit, with ready-based back-pressure, bubble collapsing and an occupancy count. It sits between producers such as the time-base counters and the BCD/segment formatting logic, wherever a multi-cycle, stallable delay is needed.

## Interface
- WIDTH, 4: data bits per stage (≥1)
- DEPTH, 2: number of register stages (≥1)
- CW: log2 width of o_Count, derived as $clog2(DEPTH+1); not overridden by users
- i_Clk  input  1  sole clock; all state updates on posedge
- i_Rst_n  input  1  reset, asynchronous assert, active-low
- i_Din  input  WIDTH  upstream data
- i_Valid  input  1  upstream data valid
- o_Ready  output  1  pipeline can accept this cycle
- o_Qout  output  WIDTH  data of last stage
- o_Valid  output  1  last stage holds valid data
- i_Ready  input  1  downstream accepts this cycle
- o_Count  output  CW  number of valid stages, 0..DEPTH
- i_Clr  input  1  synchronous flush (present only with CW_REG_PIPE_CLR_EN)

## Operation
- Stage k holds v[k] and d[k]. Stage 0 is fed by i_Valid/i_Din. Stage DEPTH-1 drives o_Valid/o_Qout.
- Stage ready: r[DEPTH-1] = !v[DEPTH-1] | i_Ready; r[k] = !v[k] | r[k+1]; o_Ready = r[0]. Combinational, no registered ready.
- Each clock, if r[k]: v[k] <= v[k-1] (v[-1] = i_Valid); d[k] <= d[k-1] only when the incoming valid is 1, otherwise d[k] holds.
- If !r[k]: stage holds v and d.
- Input accept = i_Valid & o_Ready; output accept = o_Valid & i_Ready.
- o_Count: +1 on input accept only, -1 on output accept only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Bubbles collapse: an empty stage always accepts, even when downstream stalls.
- Data order is strictly FIFO. No beat is dropped or duplicated.
- Upstream may drop i_Valid freely. Downstream may drop i_Ready freely. No protocol checking.

## Timing
- Reset (i_Rst_n low, asynchronous): all v[k] = 0, all d[k] = 0, o_Valid = 0, o_Qout = 0, o_Count = 0. o_Ready = 1 while in reset.
- Reset release is synchronous to the next posedge.
- Reset mid-operation discards all in-flight data immediately.
- Latency with no stalls: a beat accepted at edge n appears on o_Qout/o_Valid after edge n+DEPTH-1. That is, DEPTH registers and DEPTH cycles from i_Din to o_Qout.
- Throughput is 1 beat/cycle when i_Ready stays high.
- Full (o_Count = DEPTH) with i_Ready = 1: o_Ready = 1, and simultaneous accept and emit leaves the count unchanged.
- Full with i_Ready = 0: o_Ready = 0 and all stages hold.
- Empty: o_Valid = 0 and o_Qout keeps its last value.

## Configuration
- CW_REG_PIPE_CLR_EN defined: i_Clr port exists.
  - i_Clr = 1 at a posedge sets all v[k] = 0 and o_Count = 0. d[k] is unchanged.
  - Clear overrides any same-cycle input or output accept, and the accepted input beat is discarded.
  - o_Ready is not affected by i_Clr.
- CW_REG_PIPE_CLR_EN undefined: no i_Clr port and no clear logic. Behaviour is otherwise identical.

## Structure
- Shared package cw_clock_pkg holds the default WIDTH/DEPTH constants used across the clock datapath, plus the clog2 helper function.
- Natural sub-module: cw_pipe_stage (one valid+data stage with a ready chain in/out), instantiated DEPTH times in a generate loop.
- The occupancy counter and the clear logic live in cw_reg_pipe.

## Test plan
- Reset: hold i_Rst_n = 0 mid-stream with DEPTH = 3 -> o_Valid = 0, o_Count = 0, o_Qout = 0 immediately, without waiting for a clock edge.
- Streaming: WIDTH = 4, DEPTH = 3, i_Ready = 1, feed 0x1..0x9 back-to-back -> 0x1 on o_Qout 3 cycles after acceptance, then one value per cycle, in order, o_Count = 3 steady.
- Back-pressure: fill DEPTH = 3 with i_Ready = 0 -> o_Ready = 0 after 3 accepts, o_Count = 3. Release i_Ready for 1 cycle -> exactly one beat out, o_Ready = 1 that same cycle, count stays 3 if a new beat is accepted.
- Bubble collapse: send 0xA, gap 2 cycles, 0xB with i_Ready = 0 -> both held in the last two stages, o_Count = 2, o_Ready = 1.
- Clear (CW_REG_PIPE_CLR_EN): pipeline holding 0x5, 0x6 with i_Clr = 1 and i_Valid = 1 (0x7) -> next cycle o_Valid = 0, o_Count = 0, and 0x7 is never emitted.
- Randomised valid/ready over 1000 cycles, DEPTH = 1 and DEPTH = 4 -> scoreboard order matches and o_Count equals the scoreboard depth every cycle.

Source files
------------

// File: rtl/cw_clock_pkg.sv
// Shared constants and helpers for the digital clock datapath.
package cw_clock_pkg;

  localparam int unsigned CW_WIDTH = 4;
  localparam int unsigned CW_DEPTH = 2;

  // Ceiling log2; returns 0 for x <= 1.
  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    int unsigned v;
    r = 0;
    if (x > 1) begin
      v = x - 1;
      while (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cw_reg_pipe_if.sv
// Valid/ready stream plus occupancy for cw_reg_pipe; slave = pipeline side.
interface cw_reg_pipe_if
  import cw_clock_pkg::*;
#(
  parameter int unsigned WIDTH = CW_WIDTH,
  parameter int unsigned DEPTH = CW_DEPTH
);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] i_Din;
  logic             i_Valid;
  logic             o_Ready;
  logic [WIDTH-1:0] o_Qout;
  logic             o_Valid;
  logic             i_Ready;
  logic [CW-1:0]    o_Count;

  modport slave (
    input  i_Din, i_Valid, i_Ready,
    output o_Ready, o_Qout, o_Valid, o_Count
  );

  modport master (
    output i_Din, i_Valid, i_Ready,
    input  o_Ready, o_Qout, o_Valid, o_Count
  );

endinterface

// File: rtl/cw_pipe_stage.sv
// One valid+data register stage; ready_c = !valid | next_ready lets bubbles collapse.
module cw_pipe_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready_c
);

  assign ready_c = !valid | next_ready;

  // Data only loads on a real incoming beat, so an idle stage keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (ready_c) begin
        valid <= in_valid;
        if (in_valid) begin
          data <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/cw_reg_pipe.sv
// DEPTH-stage flow-controlled register pipeline with occupancy count.
// Optional synchronous flush input i_Clr when CW_REG_PIPE_CLR_EN is defined.
module cw_reg_pipe
  import cw_clock_pkg::*;
#(
  parameter int unsigned WIDTH = CW_WIDTH,
  parameter int unsigned DEPTH = CW_DEPTH
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
`ifdef CW_REG_PIPE_CLR_EN
  input  logic         i_Clr,
`endif
  cw_reg_pipe_if.slave bus
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic             v   [DEPTH];
  logic [WIDTH-1:0] d   [DEPTH];
  logic             vin [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  logic             r   [DEPTH+1];
  logic             flush_c;
  logic             in_acc_c;
  logic             out_acc_c;
  logic [CW-1:0]    count;

`ifdef CW_REG_PIPE_CLR_EN
  assign flush_c = i_Clr;
`else
  assign flush_c = 1'b0;
`endif

  assign r[DEPTH] = bus.i_Ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = bus.i_Valid;
      assign din[k] = bus.i_Din;
    end else begin : g_body
      assign vin[k] = v[k-1];
      assign din[k] = d[k-1];
    end

    cw_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (i_Clk),
      .rst_n      (i_Rst_n),
      .flush      (flush_c),
      .in_valid   (vin[k]),
      .in_data    (din[k]),
      .next_ready (r[k+1]),
      .valid      (v[k]),
      .data       (d[k]),
      .ready_c    (r[k])
    );
  end

  assign in_acc_c  = bus.i_Valid & r[0];
  assign out_acc_c = v[DEPTH-1] & bus.i_Ready;

  // Occupancy: simultaneous accept and emit cancel out.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count <= '0;
    end else if (flush_c) begin
      count <= '0;
    end else if (in_acc_c && !out_acc_c) begin
      count <= count + CW'(1);
    end else if (!in_acc_c && out_acc_c) begin
      count <= count - CW'(1);
    end
  end

  assign bus.o_Ready = r[0];
  assign bus.o_Valid = v[DEPTH-1];
  assign bus.o_Qout  = d[DEPTH-1];
  assign bus.o_Count = count;

endmodule

// File: tb/tb_cw_reg_pipe.sv
// Bench for cw_reg_pipe: directed tests on DEPTH=3, scoreboarded random traffic on DEPTH=1 and 4.
module tb_cw_reg_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic mr1;
  logic mr4;
  logic [3:0] q1[$];
  logic [3:0] q4[$];

  always #5 clk = ~clk;

  cw_reg_pipe_if #(.WIDTH(4), .DEPTH(3)) bus3 ();
  cw_reg_pipe_if #(.WIDTH(4), .DEPTH(1)) bus1 ();
  cw_reg_pipe_if #(.WIDTH(4), .DEPTH(4)) bus4 ();

`ifdef CW_REG_PIPE_CLR_EN
  logic clr3 = 1'b0;
  logic clr_idle = 1'b0;
`endif

  cw_reg_pipe #(.WIDTH(4), .DEPTH(3)) u_dut3 (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
`ifdef CW_REG_PIPE_CLR_EN
    .i_Clr   (clr3),
`endif
    .bus     (bus3.slave)
  );

  cw_reg_pipe #(.WIDTH(4), .DEPTH(1)) u_dut1 (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
`ifdef CW_REG_PIPE_CLR_EN
    .i_Clr   (clr_idle),
`endif
    .bus     (bus1.slave)
  );

  cw_reg_pipe #(.WIDTH(4), .DEPTH(4)) u_dut4 (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
`ifdef CW_REG_PIPE_CLR_EN
    .i_Clr   (clr_idle),
`endif
    .bus     (bus4.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the DEPTH=3 pipe after a falling edge, then settle before sampling.
  task automatic drive3(input logic v, input logic [3:0] dt, input logic rd);
    @(negedge clk);
    bus3.i_Valid = v;
    bus3.i_Din   = dt;
    bus3.i_Ready = rd;
    #1;
  endtask

  initial begin
    int acc;
    int em;
    bus3.i_Valid = 1'b0; bus3.i_Din = 4'h0; bus3.i_Ready = 1'b0;
    bus1.i_Valid = 1'b0; bus1.i_Din = 4'h0; bus1.i_Ready = 1'b0;
    bus4.i_Valid = 1'b0; bus4.i_Din = 4'h0; bus4.i_Ready = 1'b0;

    #1;
    check("rst_valid", 32'(bus3.o_Valid), 0);
    check("rst_count", 32'(bus3.o_Count), 0);
    check("rst_qout",  32'(bus3.o_Qout),  0);
    check("rst_ready", 32'(bus3.o_Ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back streaming 1..9 with downstream always ready.
    for (int j = 0; j < 13; j++) begin
      drive3(j < 9, 4'(j + 1), 1'b1);
      acc = (j < 9) ? j : 9;
      em  = ((j < 12) ? j : 12) - 3;
      if (em < 0) em = 0;
      check("stream_count", 32'(bus3.o_Count), 32'(acc - em));
      check("stream_valid", 32'(bus3.o_Valid), 32'(j >= 3 && j < 12));
      if (j >= 3 && j < 12) check("stream_data", 32'(bus3.o_Qout), 32'(j - 2));
      if (j == 12) check("empty_hold_qout", 32'(bus3.o_Qout), 32'h9);
    end

    // Back-pressure: fill with C,D,E while downstream stalls.
    drive3(1'b1, 4'hC, 1'b0);
    drive3(1'b1, 4'hD, 1'b0);
    drive3(1'b1, 4'hE, 1'b0);
    drive3(1'b1, 4'hF, 1'b0);
    check("bp_full_ready", 32'(bus3.o_Ready), 0);
    check("bp_full_count", 32'(bus3.o_Count), 3);
    check("bp_full_qout",  32'(bus3.o_Qout),  32'hC);
    drive3(1'b1, 4'hF, 1'b0);
    check("bp_hold_count", 32'(bus3.o_Count), 3);
    check("bp_hold_qout",  32'(bus3.o_Qout),  32'hC);
    drive3(1'b1, 4'hF, 1'b1);
    check("bp_release_ready", 32'(bus3.o_Ready), 1);
    drive3(1'b0, 4'h0, 1'b0);
    check("bp_after_count", 32'(bus3.o_Count), 3);
    check("bp_after_qout",  32'(bus3.o_Qout),  32'hD);
    check("bp_after_ready", 32'(bus3.o_Ready), 0);
    drive3(1'b0, 4'h0, 1'b1);
    check("bp_drain_d", 32'(bus3.o_Qout), 32'hD);
    drive3(1'b0, 4'h0, 1'b1);
    check("bp_drain_e", 32'(bus3.o_Qout), 32'hE);
    drive3(1'b0, 4'h0, 1'b1);
    check("bp_drain_f", 32'(bus3.o_Qout), 32'hF);
    drive3(1'b0, 4'h0, 1'b1);
    check("bp_empty_valid", 32'(bus3.o_Valid), 0);
    check("bp_empty_count", 32'(bus3.o_Count), 0);

    // Bubble collapse: A, two idle cycles, B, downstream stalled.
    drive3(1'b1, 4'hA, 1'b0);
    drive3(1'b0, 4'h0, 1'b0);
    drive3(1'b0, 4'h0, 1'b0);
    drive3(1'b1, 4'hB, 1'b0);
    drive3(1'b0, 4'h0, 1'b0);
    drive3(1'b0, 4'h0, 1'b0);
    check("bub_count", 32'(bus3.o_Count), 2);
    check("bub_ready", 32'(bus3.o_Ready), 1);
    check("bub_valid", 32'(bus3.o_Valid), 1);
    check("bub_qout",  32'(bus3.o_Qout),  32'hA);
    drive3(1'b0, 4'h0, 1'b1);
    check("bub_out_a", 32'(bus3.o_Qout), 32'hA);
    drive3(1'b0, 4'h0, 1'b1);
    check("bub_out_b", 32'(bus3.o_Qout), 32'hB);
    drive3(1'b0, 4'h0, 1'b0);
    check("bub_empty_count", 32'(bus3.o_Count), 0);

`ifdef CW_REG_PIPE_CLR_EN
    // Clear overrides a same-cycle accept; 7 must never appear.
    drive3(1'b1, 4'h5, 1'b0);
    drive3(1'b1, 4'h6, 1'b0);
    @(negedge clk);
    bus3.i_Valid = 1'b1; bus3.i_Din = 4'h7; bus3.i_Ready = 1'b0; clr3 = 1'b1;
    #1;
    check("clr_ready", 32'(bus3.o_Ready), 1);
    @(negedge clk);
    clr3 = 1'b0;
    bus3.i_Valid = 1'b0; bus3.i_Ready = 1'b1;
    #1;
    check("clr_valid", 32'(bus3.o_Valid), 0);
    check("clr_count", 32'(bus3.o_Count), 0);
    for (int j = 0; j < 4; j++) begin
      drive3(1'b0, 4'h0, 1'b1);
      check("clr_no_emit", 32'(bus3.o_Valid), 0);
    end
`endif

    // Asynchronous reset in the middle of a cycle with data in flight.
    drive3(1'b1, 4'h3, 1'b0);
    drive3(1'b1, 4'h4, 1'b0);
    drive3(1'b0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus3.o_Valid), 0);
    check("midrst_count", 32'(bus3.o_Count), 0);
    check("midrst_qout",  32'(bus3.o_Qout),  0);
    check("midrst_ready", 32'(bus3.o_Ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Random valid/ready on DEPTH=1 and DEPTH=4 against FIFO scoreboards.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus1.i_Valid = ($urandom_range(0, 3) != 0);
      bus1.i_Din   = 4'($urandom);
      bus1.i_Ready = ($urandom_range(0, 2) != 0);
      bus4.i_Valid = ($urandom_range(0, 3) != 0);
      bus4.i_Din   = 4'($urandom);
      bus4.i_Ready = ($urandom_range(0, 1) == 1);
      #1;

      check("d1_count", 32'(bus1.o_Count), 32'(q1.size()));
      mr1 = (q1.size() < 1) || bus1.i_Ready;
      check("d1_ready", 32'(bus1.o_Ready), 32'(mr1));
      if (bus1.o_Valid && bus1.i_Ready) begin
        if (q1.size() == 0) check("d1_spurious", 32'(bus1.o_Valid), 0);
        else check("d1_data", 32'(bus1.o_Qout), 32'(q1.pop_front()));
      end
      if (bus1.i_Valid && mr1) q1.push_back(bus1.i_Din);

      check("d4_count", 32'(bus4.o_Count), 32'(q4.size()));
      mr4 = (q4.size() < 4) || bus4.i_Ready;
      check("d4_ready", 32'(bus4.o_Ready), 32'(mr4));
      if (bus4.o_Valid && bus4.i_Ready) begin
        if (q4.size() == 0) check("d4_spurious", 32'(bus4.o_Valid), 0);
        else check("d4_data", 32'(bus4.o_Qout), 32'(q4.pop_front()));
      end
      if (bus4.i_Valid && mr4) q4.push_back(bus4.i_Din);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
